// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA-style display, 640x480 @ 60 Hz by
// default, running on the 25 MHz pixel clock from the PLL. The generator
// stays idle until the PLL reports lock. It drops back to idle the moment
// lock is lost. Each new lock starts a fresh frame at pixel (0,0).
//
// Ports
//   clk          pixel clock (PLL outclk_0)
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock indicator, asynchronous to clk
//   hsync        horizontal sync, polarity set by HS_POL
//   vsync        vertical sync, polarity set by VS_POL
//   de           active-video enable
//   x, y         pixel column / row, forced to 0 outside active video
//   line_start   one-clock pulse at the first pixel of every visible line
//   frame_start  one-clock pulse at the first pixel of every frame
//   running      high while the raster is being generated
//
// All outputs are registered. They lag the internal counters by one clock.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open ranges [BEG, END). Decoding happens in
    // 32-bit integer space, so an END equal to TOTAL cannot overflow CNT_W.
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             lk_meta;
    logic             lk_s;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    logic             run_ok;

    logic             hsync_d;
    logic             vsync_d;
    logic             de_d;
    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] y_d;
    logic             line_start_d;
    logic             frame_start_d;
    logic             running_d;

    // pll_locked comes from the PLL's own timing domain. Pass it through two
    // flops before any logic uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Leave IDLE only on a synchronised lock. Any sampled
    // loss of lock while running sends the FSM back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lk_s)  state_next = RUN;
            RUN:     if (!lk_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The raster advances only while running with lock still present.
    // Lock loss is handled on the same edge that leaves RUN, so the counters
    // and outputs clear together and never expose a stale pixel.
    assign run_ok = (state == RUN) && lk_s;

    // Raster counters. IDLE and the lock-loss edge both produce 0, so a
    // later restart always begins at pixel (0,0). The wrap tests use >=,
    // so a counter can never run past its last legal value.
    always_comb begin
        h_next = '0;
        v_next = '0;
        if (run_ok) begin
            if (h_cnt >= H_LAST) begin
                h_next = '0;
                if (v_cnt >= V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = v_cnt + CNT_W'(1);
                end
            end else begin
                h_next = h_cnt + CNT_W'(1);
                v_next = v_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Decode the current raster position into the output values for the
    // next clock. While not running, the decode yields the idle values.
    // vsync depends only on the line count, so it changes at the start of
    // a line, together with h = 0.
    always_comb begin
        int h_pos;
        int v_pos;
        h_pos         = int'(h_cnt);
        v_pos         = int'(v_cnt);
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (run_ok) begin
            running_d     = 1'b1;
            de_d          = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
            if (de_d) begin
                x_d = h_cnt;
                y_d = v_cnt;
            end
            if ((h_pos >= HS_BEG) && (h_pos < HS_END)) begin
                hsync_d = HS_POL;
            end
            if ((v_pos >= VS_BEG) && (v_pos < VS_END)) begin
                vsync_d = VS_POL;
            end
            line_start_d  = (h_pos == 0) && (v_pos < V_ACTIVE);
            frame_start_d = (h_pos == 0) && (v_pos == 0);
        end
    end

    // Output register. Every output is a flop, so downstream logic sees
    // clean, glitch-free sync and strobe signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            de          <= de_d;
            x           <= x_d;
            y           <= y_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
            running     <= running_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two vga_timing_gen instances from the same clock, reset and lock
// signal. One instance uses the default 640x480 timing. The other uses a tiny
// 4/1/1/1 x 3/1/1/1 raster, so whole frames go by quickly.
//
// The reference model is raster arithmetic. It tracks which sampled lock
// history allows output and how many pixels have been emitted since the last
// restart. From that pixel index it derives h = p mod H_TOTAL and
// v = (p / H_TOTAL) mod V_TOTAL, then applies the timing rules.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic       run;
    } vid_t;

    localparam vid_t RESET_VID = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
    localparam vid_t START_VID = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;

    logic       def_hsync, def_vsync, def_de, def_ls, def_fs, def_run;
    logic [9:0] def_x, def_y;
    logic       sm_hsync, sm_vsync, sm_de, sm_ls, sm_fs, sm_run;
    logic [9:0] sm_x, sm_y;

    vid_t vid_def;
    vid_t vid_small;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .hsync       (def_hsync),
        .vsync       (def_vsync),
        .de          (def_de),
        .x           (def_x),
        .y           (def_y),
        .line_start  (def_ls),
        .frame_start (def_fs),
        .running     (def_run)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .hsync       (sm_hsync),
        .vsync       (sm_vsync),
        .de          (sm_de),
        .x           (sm_x),
        .y           (sm_y),
        .line_start  (sm_ls),
        .frame_start (sm_fs),
        .running     (sm_run)
    );

    assign vid_def   = {def_hsync, def_vsync, def_de, def_x, def_y, def_ls, def_fs, def_run};
    assign vid_small = {sm_hsync, sm_vsync, sm_de, sm_x, sm_y, sm_ls, sm_fs, sm_run};

    // Expected outputs for pixel index p since the last restart, under the
    // given raster geometry. Active-low syncs are assumed.
    function automatic vid_t expect_vid(input logic active, input int p,
                                        input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp);
        vid_t e;
        int   ht;
        int   vt;
        int   h;
        int   v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        h  = p % ht;
        v  = (p / ht) % vt;
        e  = RESET_VID;
        if (active) begin
            e.run = 1'b1;
            e.de  = (h < ha) && (v < va);
            if (e.de) begin
                e.x = 10'(h);
                e.y = 10'(v);
            end
            e.hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
            e.vs = !((v >= va + vfp) && (v < va + vfp + vsw));
            e.ls = (h == 0) && (v < va);
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    function automatic vid_t expect_def(input logic active, input int p);
        return expect_vid(active, p, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic vid_t expect_small(input logic active, input int p);
        return expect_vid(active, p, 4, 1, 1, 1, 3, 1, 1, 1);
    endfunction

    // Lock-history model. The generator emits on a clock only if lock was
    // sampled high on both the 3rd and 2nd previous edges. Each emitted
    // clock advances the pixel index. Any gap restarts the index at 0.
    logic [2:0] hist = 3'b000;
    logic       act = 1'b0;
    int         pix = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b000;
            act  <= 1'b0;
            pix  <= 0;
        end else begin
            hist <= {hist[1:0], pll_locked};
            act  <= hist[2] && hist[1];
            pix  <= (hist[2] && hist[1]) ? (act ? pix + 1 : 0) : 0;
        end
    end

    task automatic checkOutput(input string name, input vid_t got, input vid_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Cycle compare of both instances against the model, away from the
    // active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_def", vid_def, expect_def(act, pix));
            checkOutput("cyc_small", vid_small, expect_small(act, pix));
        end
    end

    // Inputs change 1 time unit after a rising edge. The task then waits
    // the given number of edges.
    task automatic applyStimulus(input logic rst_v, input logic lock_v, input int cycles);
        rst_n      = rst_v;
        pll_locked = lock_v;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges from the current drive point until frame_start. The
    // first edge after the drive point counts as 1, so the expected
    // frame_start lands on count 4.
    task automatic restartLatency(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!def_fs && n < 20);
        checkValue({name, "_latency"}, n, 4);
        checkOutput({name, "_start_def"}, vid_def, START_VID);
        checkOutput({name, "_start_small"}, vid_small, START_VID);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vid_t pin;
        int   de_cnt;
        int   hs_cnt;
        int   hs_first;
        int   ls_cnt;
        int   x639;
        int   x640;
        int   vs_cnt;
        int   vs_first;
        int   n;
        logic [6:0] de_pat;
        logic [6:0] hs_pat;

        // Pin the model against hand-computed raster points.
        pin = expect_def(1'b1, 656);
        checkValue("pin_hs_656", pin.hs, 0);
        pin = expect_def(1'b1, 655);
        checkValue("pin_hs_655", pin.hs, 1);
        pin = expect_def(1'b1, 490 * 800);
        checkValue("pin_vs_490", pin.vs, 0);
        checkOutput("pin_small_wrap", expect_small(1'b1, 42), START_VID);

        // Reset held while lock is already present.
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("reset_def", vid_def, RESET_VID);
        checkOutput("reset_small", vid_small, RESET_VID);

        // Release reset. The first frame starts 3 clocks after the first
        // sampling edge.
        applyStimulus(1'b1, 1'b1, 0);
        restartLatency("release");

        // One full default line, starting on the frame_start sample.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; x639 = -1; x640 = -1;
        for (int i = 0; i < 800; i++) begin
            if (def_de) de_cnt++;
            if (!def_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (i > 0 && def_ls) ls_cnt++;
            if (i == 639) x639 = int'(def_x);
            if (i == 640) x640 = int'(def_x);
            @(posedge clk);
            #1;
        end
        checkValue("line_de_count", de_cnt, 640);
        checkValue("line_hs_count", hs_cnt, 96);
        checkValue("line_hs_first", hs_first, 656);
        checkValue("line_ls_inside", ls_cnt, 0);
        checkValue("line_ls_at_800", def_ls, 1);
        checkValue("line_x639", x639, 639);
        checkValue("line_x640", x640, 0);

        // One full frame of the small raster (7 x 6 = 42 clocks).
        n = 0;
        while (!sm_fs && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue("small_fs_found", sm_fs, 1);
        vs_cnt = 0; vs_first = -1; ls_cnt = 0; de_pat = '0; hs_pat = '0;
        for (int i = 0; i < 42; i++) begin
            if (!sm_vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (sm_ls) ls_cnt++;
            if (i < 7) begin
                de_pat = {de_pat[5:0], sm_de};
                hs_pat = {hs_pat[5:0], sm_hsync};
            end
            @(posedge clk);
            #1;
        end
        checkValue("small_vs_count", vs_cnt, 7);
        checkValue("small_vs_first", vs_first, 28);
        checkValue("small_ls_count", ls_cnt, 3);
        checkValue("small_de_line0", int'(de_pat), 7'b1111000);
        checkValue("small_hs_line0", int'(hs_pat), 7'b1111101);
        checkValue("small_fs_at_42", sm_fs, 1);

        // Lock loss in the middle of line 3, pixel 300 of the default raster.
        n = 0;
        while (!(def_y == 10'd3 && def_x == 10'd300) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue("reach_y3_x300", int'(def_y == 10'd3 && def_x == 10'd300), 1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("loss_def", vid_def, RESET_VID);
        checkOutput("loss_small", vid_small, RESET_VID);
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b1, 1'b1, 0);
        restartLatency("relock");
        applyStimulus(1'b1, 1'b1, 200);

        // A single-clock low on lock still forces a restart. The cycle
        // compare covers it.
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 150);

        // Short asynchronous reset pulse between clock edges.
        applyStimulus(1'b1, 1'b1, 500);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_def", vid_def, RESET_VID);
        checkOutput("areset_small", vid_small, RESET_VID);
        #1;
        rst_n = 1'b1;
        restartLatency("areset");
        applyStimulus(1'b1, 1'b1, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
